// File: rtl/read_burst_pkg.sv
// Shared types and helpers for the read burst planner.
// FSM states plus beat/byte derivation used at elaboration time.
package read_burst_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CALC0,
    S_CALC1,
    S_ISSUE,
    S_NEXT,
    S_DRAIN,
    S_DONE
  } state_t;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++)
      if ((1 << i) < v) r = i + 1;
    return r;
  endfunction

  function automatic int bytes_per_beat(input int axi_dsize);
    return axi_dsize / 8;
  endfunction

  function automatic int beat_shift(input int axi_dsize);
    return clog2(axi_dsize);
  endfunction

endpackage

// File: rtl/burst_len_clip.sv
// Burst length clip: min(remaining, MAX_BURST[, 4 KB page room]).
// Page-room limit only exists when RD_BURST_4K_SPLIT_EN is defined.
module burst_len_clip
  import read_burst_pkg::*;
#(
  parameter int MAX_BURST = 200,
`ifdef RD_BURST_4K_SPLIT_EN
  parameter int AXI_DSIZE = 256,
`endif
  parameter int LSIZE     = 9
) (
  input  logic [31:0]      remaining,
`ifdef RD_BURST_4K_SPLIT_EN
  input  logic [11:0]      page_off,
`endif
  output logic [LSIZE-1:0] len,
  output logic             tail
);

  localparam logic [31:0] MAXB = 32'(MAX_BURST);

  logic [31:0] lim;
  logic [31:0] eff;

`ifdef RD_BURST_4K_SPLIT_EN
  localparam int BSH = clog2(bytes_per_beat(AXI_DSIZE));

  logic [12:0] room;
  logic [31:0] page;

  assign room = 13'h1000 - {1'b0, page_off};
  assign page = 32'(room >> BSH);

  // an unaligned offset could leave less than one beat; never emit len 0
  always_comb begin
    lim = MAXB;
    if (page == 32'd0)
      lim = 32'd1;
    else if (page < MAXB)
      lim = page;
  end
`else
  assign lim = MAXB;
`endif

  assign eff  = (remaining < lim) ? remaining : lim;
  assign len  = eff[LSIZE-1:0];
  assign tail = eff < MAXB;

endmodule

// File: rtl/read_burst_planner.sv
// Frame/line read-burst planner with outstanding-burst throttle.
// Optional 4 KB boundary split: define RD_BURST_4K_SPLIT_EN.
module read_burst_planner
  import read_burst_pkg::*;
#(
  parameter int MAX_BURST       = 200,
  parameter int AXI_DSIZE       = 256,
  parameter int DSIZE           = 24,
  parameter int LSIZE           = 9,
  parameter int ASIZE           = 32,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic             clock,
  input  logic             rst_n,
  input  logic             fsync,
  input  logic             mode_line,
  input  logic [15:0]      vactive,
  input  logic [15:0]      hactive,
  input  logic [ASIZE-1:0] base_addr,
  input  logic [ASIZE-1:0] line_stride,
  output logic             cmd_valid,
  input  logic             cmd_ready,
  output logic [ASIZE-1:0] cmd_addr,
  output logic [LSIZE-1:0] cmd_len,
  output logic             cmd_tail,
  output logic             cmd_last,
  input  logic             burst_done,
  output logic             busy,
  output logic             frame_done
);

  localparam int BSHIFT = beat_shift(AXI_DSIZE);
  localparam int ASHIFT = clog2(bytes_per_beat(AXI_DSIZE));
  localparam int OW     = clog2(MAX_OUTSTANDING + 1);
  localparam logic [OW-1:0] OMAX = OW'(MAX_OUTSTANDING);

  state_t state, nxt_state;

  logic             mode_q;
  logic [15:0]      vact_q, hact_q;
  logic [ASIZE-1:0] base_q, stride_q;
  logic [31:0]      prod_q, beats_q;
  logic [31:0]      remaining, nxt_remaining;
  logic [15:0]      lines_left, nxt_lines;
  logic [ASIZE-1:0] line_addr;
  logic [ASIZE-1:0] addr, nxt_addr;
  logic [OW-1:0]    outstanding, nxt_out;

  logic             hs, done_ok;
  logic [31:0]      pix, beats_calc;
  logic [15:0]      lines_calc;
  logic [ASIZE-1:0] step_bytes;
  logic [LSIZE-1:0] clip_len;
  logic             clip_tail;
  logic             o_issue, o_valid, o_last;

  assign hs      = cmd_valid & cmd_ready;
  assign done_ok = burst_done & (outstanding != '0);

  assign pix = mode_q ? 32'(hact_q)
                      : 32'(vact_q) * 32'(hact_q);

  // ceil division: shift out the beat bits, round up on any remainder
  assign beats_calc = (prod_q >> BSHIFT)
                    + {31'b0, |prod_q[BSHIFT-1:0]};

  assign lines_calc = mode_q ? vact_q : 16'd1;
  assign step_bytes = ASIZE'(cmd_len) << ASHIFT;

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      mode_q      <= 1'b0;
      vact_q      <= '0;
      hact_q      <= '0;
      base_q      <= '0;
      stride_q    <= '0;
      prod_q      <= '0;
      beats_q     <= '0;
      remaining   <= '0;
      lines_left  <= '0;
      line_addr   <= '0;
      addr        <= '0;
      outstanding <= '0;
    end else begin
      state       <= nxt_state;
      remaining   <= nxt_remaining;
      lines_left  <= nxt_lines;
      addr        <= nxt_addr;
      outstanding <= nxt_out;
      if (fsync) begin
        mode_q   <= mode_line;
        vact_q   <= vactive;
        hact_q   <= hactive;
        base_q   <= base_addr;
        stride_q <= line_stride;
      end
      if (state == S_CALC0)
        prod_q <= pix * 32'(DSIZE);
      if (state == S_CALC1) begin
        beats_q   <= beats_calc;
        line_addr <= base_q;
      end
      if (state == S_NEXT)
        line_addr <= line_addr + stride_q;
    end
  end

  always_comb begin
    nxt_state     = state;
    nxt_remaining = remaining;
    nxt_lines     = lines_left;
    nxt_addr      = addr;
    unique case (state)
      S_IDLE:  if (fsync) nxt_state = S_CALC0;
      S_CALC0: nxt_state = S_CALC1;
      S_CALC1: begin
        nxt_remaining = beats_calc;
        nxt_lines     = lines_calc;
        nxt_addr      = base_q;
        if (beats_calc == 32'd0 || lines_calc == 16'd0)
          nxt_state = S_DONE;
        else
          nxt_state = S_ISSUE;
      end
      S_ISSUE: if (hs) begin
        nxt_remaining = remaining - 32'(cmd_len);
        nxt_addr      = addr + step_bytes;
        if (nxt_remaining == 32'd0)
          nxt_state = (lines_left > 16'd1) ? S_NEXT : S_DRAIN;
      end
      S_NEXT: begin
        nxt_addr      = line_addr + stride_q;
        nxt_remaining = beats_q;
        nxt_lines     = lines_left - 16'd1;
        nxt_state     = S_ISSUE;
      end
      S_DRAIN: if (outstanding == '0) nxt_state = S_DONE;
      S_DONE:  nxt_state = S_IDLE;
      default: nxt_state = S_IDLE;
    endcase
    // a new frame start abandons whatever is in flight here
    if (fsync) nxt_state = S_CALC0;
  end

  always_comb begin
    nxt_out = outstanding;
    unique case ({hs, done_ok})
      2'b10:   nxt_out = outstanding + OW'(1);
      2'b01:   nxt_out = outstanding - OW'(1);
      default: nxt_out = outstanding;
    endcase
  end

  burst_len_clip #(
    .MAX_BURST (MAX_BURST),
`ifdef RD_BURST_4K_SPLIT_EN
    .AXI_DSIZE (AXI_DSIZE),
`endif
    .LSIZE     (LSIZE)
  ) u_clip (
    .remaining (nxt_remaining),
`ifdef RD_BURST_4K_SPLIT_EN
    .page_off  (nxt_addr[11:0]),
`endif
    .len       (clip_len),
    .tail      (clip_tail)
  );

  always_comb begin
    o_issue = (nxt_state == S_ISSUE);
    o_valid = o_issue && (nxt_out != OMAX);
    o_last  = o_issue && (nxt_lines == 16'd1)
           && (32'(clip_len) == nxt_remaining);
  end

  // outputs register the command for the state being entered
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      cmd_valid  <= 1'b0;
      cmd_addr   <= '0;
      cmd_len    <= '0;
      cmd_tail   <= 1'b0;
      cmd_last   <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      cmd_valid  <= o_valid;
      cmd_addr   <= nxt_addr;
      cmd_len    <= clip_len;
      cmd_tail   <= o_issue & clip_tail;
      cmd_last   <= o_last;
      busy       <= (nxt_state != S_IDLE);
      frame_done <= (nxt_state == S_DONE);
    end
  end

endmodule

// File: tb/tb_read_burst_planner.sv
// Directed bench for read_burst_planner.
// Expectations follow RD_BURST_4K_SPLIT_EN when it is defined.
module tb_read_burst_planner;

  logic        clock = 1'b0;
  logic        rst_n;
  logic        fsync;
  logic        mode_line;
  logic [15:0] vactive, hactive;
  logic [31:0] base_addr, line_stride;
  logic        cmd_valid, cmd_ready;
  logic [31:0] cmd_addr;
  logic [8:0]  cmd_len;
  logic        cmd_tail, cmd_last;
  logic        burst_done;
  logic        busy, frame_done;

  read_burst_planner #(
    .MAX_BURST(200), .AXI_DSIZE(256), .DSIZE(24),
    .LSIZE(9), .ASIZE(32), .MAX_OUTSTANDING(4)
  ) dut (
    .clock(clock), .rst_n(rst_n), .fsync(fsync),
    .mode_line(mode_line), .vactive(vactive),
    .hactive(hactive), .base_addr(base_addr),
    .line_stride(line_stride), .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready), .cmd_addr(cmd_addr),
    .cmd_len(cmd_len), .cmd_tail(cmd_tail),
    .cmd_last(cmd_last), .burst_done(burst_done),
    .busy(busy), .frame_done(frame_done)
  );

  always #5 clock = ~clock;

`ifdef RD_BURST_4K_SPLIT_EN
  localparam int ONCE_N = 675;
  localparam int ONCE_LEN = 128;
  localparam int ONCE_TAILS = 675;
  localparam logic [31:0] ONCE_LAST_A = 32'h102A_2000;
  localparam int L_PER = 3;
  localparam int H_N = 4;
  localparam int H_LEN0 = 128;
  localparam int R_LEN0 = 128;
  localparam int R_N = 3;
  localparam int K_N = 3;
`else
  localparam int ONCE_N = 432;
  localparam int ONCE_LEN = 200;
  localparam int ONCE_TAILS = 0;
  localparam logic [31:0] ONCE_LAST_A = 32'h102A_1700;
  localparam int L_PER = 2;
  localparam int H_N = 2;
  localparam int H_LEN0 = 129;
  localparam int R_LEN0 = 200;
  localparam int R_N = 2;
  localparam int K_N = 1;
`endif

  int l_off[3], l_len[3], l_tail[3];
  int k_addr[3], k_len[3];

  int n_chk = 0, n_pass = 0, n_fail = 0;
  int n_fd = 0, cyc = 0;
  bit last_hs = 1'b0;

  logic [31:0] q_addr[$];
  int q_len[$], q_cyc[$];
  bit q_tail[$], q_last[$];

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h",
             tag, obs, exp);
    end
  endtask

  task automatic tick();
    bit hs;
    hs = (cmd_valid === 1'b1) && (cmd_ready === 1'b1);
    if (hs) begin
      q_addr.push_back(cmd_addr);
      q_len.push_back(int'(cmd_len));
      q_tail.push_back(cmd_tail);
      q_last.push_back(cmd_last);
      q_cyc.push_back(cyc);
    end
    @(posedge clock);
    #1;
    cyc++;
    last_hs = hs;
    if (frame_done === 1'b1) n_fd++;
  endtask

  task automatic run(input int cycles, input bit auto_done);
    for (int i = 0; i < cycles; i++) begin
      tick();
      burst_done = auto_done && last_hs;
      if (frame_done === 1'b1) break;
    end
  endtask

  task automatic clear();
    q_addr.delete(); q_len.delete(); q_cyc.delete();
    q_tail.delete(); q_last.delete();
    n_fd = 0;
  endtask

  task automatic start(input bit m, input int v, input int h,
                       input logic [31:0] b, input logic [31:0] s);
    mode_line = m; vactive = 16'(v); hactive = 16'(h);
    base_addr = b; line_stride = s;
    fsync = 1'b1;
    tick();
    fsync = 1'b0;
  endtask

  initial begin
    int bad, tails, lasts, ln, k;
`ifdef RD_BURST_4K_SPLIT_EN
    l_off = '{0, 'h1000, 'h2000};
    l_len = '{128, 128, 119};
    l_tail = '{1, 1, 1};
    k_addr = '{'hF00, 'h1000, 'h2000};
    k_len = '{8, 128, 44};
`else
    l_off = '{0, 6400, 0};
    l_len = '{200, 175, 0};
    l_tail = '{0, 1, 0};
    k_addr = '{'hF00, 0, 0};
    k_len = '{180, 0, 0};
`endif
    rst_n = 0; fsync = 0; mode_line = 0;
    vactive = 0; hactive = 0; base_addr = 0;
    line_stride = 0; cmd_ready = 0; burst_done = 0;
    repeat (3) @(posedge clock);
    #1;
    chk("rst_valid", cmd_valid, 0);
    chk("rst_addr", cmd_addr, 0);
    chk("rst_len", cmd_len, 0);
    chk("rst_tail", cmd_tail, 0);
    chk("rst_last", cmd_last, 0);
    chk("rst_busy", busy, 0);
    chk("rst_fdone", frame_done, 0);
    rst_n = 1;
    tick(); tick();
    chk("idle_busy", busy, 0);

    // ONCE 1280x720
    clear();
    cmd_ready = 1;
    start(0, 720, 1280, 32'h1000_0000, 0);
    chk("once_busy", busy, 1);
    chk("once_t1", cmd_valid, 0);
    tick();
    chk("once_t2", cmd_valid, 0);
    tick();
    chk("once_t3", cmd_valid, 1);
    chk("once_a0", cmd_addr, 32'h1000_0000);
    chk("once_l0", cmd_len, ONCE_LEN);
    run(3000, 1);
    chk("once_n", q_len.size(), ONCE_N);
    bad = 0; tails = 0; lasts = 0;
    foreach (q_len[i]) begin
      if (q_len[i] != ONCE_LEN) bad++;
      tails += int'(q_tail[i]);
      lasts += int'(q_last[i]);
    end
    chk("once_lens", bad, 0);
    chk("once_tails", tails, ONCE_TAILS);
    chk("once_lasts", lasts, 1);
    chk("once_lastpos", q_last[ONCE_N-1], 1);
    chk("once_lastaddr", q_addr[ONCE_N-1], ONCE_LAST_A);
    chk("once_fd", n_fd, 1);
    tick();
    chk("once_idle", busy, 0);
    chk("once_fd_pulse", frame_done, 0);

    // LINE 3 x 4000, stride 0x4000
    clear();
    start(1, 3, 4000, 0, 32'h4000);
    run(300, 1);
    chk("line_n", q_len.size(), 3 * L_PER);
    for (int i = 0; i < 3 * L_PER; i++) begin
      ln = i / L_PER; k = i % L_PER;
      chk($sformatf("line_a%0d", i), q_addr[i],
          32'(ln * 'h4000 + l_off[k]));
      chk($sformatf("line_l%0d", i), q_len[i], l_len[k]);
      chk($sformatf("line_t%0d", i), q_tail[i], l_tail[k]);
      chk($sformatf("line_z%0d", i), q_last[i],
          (i == 3 * L_PER - 1) ? 1 : 0);
    end
    chk("line_b2b", q_cyc[1] - q_cyc[0], 1);
    chk("line_bubble", q_cyc[L_PER] - q_cyc[L_PER-1], 2);
    chk("line_fd", n_fd, 1);
    tick();

    // LINE 2 x 1366: rounded-up beats
    clear();
    start(1, 2, 1366, 0, 32'h1000);
    run(200, 1);
    chk("h1366_n", q_len.size(), H_N);
    chk("h1366_l0", q_len[0], H_LEN0);
    chk("h1366_t0", q_tail[0], 1);
    chk("h1366_z0", q_last[0], 0);
    chk("h1366_a1", q_addr[H_N/2], 32'h1000);
    chk("h1366_zl", q_last[H_N-1], 1);
    chk("h1366_fd", n_fd, 1);
    tick();

    // throttle with burst_done withheld
    clear();
    start(0, 720, 1280, 0, 0);
    run(20, 0);
    chk("thr_n", q_len.size(), 4);
    chk("thr_block", cmd_valid, 0);
    chk("thr_busy", busy, 1);
    cmd_ready = 0; burst_done = 1;
    tick();
    burst_done = 0;
    chk("thr_resume", cmd_valid, 1);
    cmd_ready = 1; burst_done = 1;
    tick();
    burst_done = 0;
    chk("thr_same_valid", cmd_valid, 1);
    chk("thr_same_n", q_len.size(), 5);
    tick();
    chk("thr_full_again", cmd_valid, 0);
    chk("thr_n2", q_len.size(), 6);
    cmd_ready = 0; burst_done = 1;
    repeat (4) tick();
    burst_done = 0;
    chk("thr_drained", cmd_valid, 1);

    // fsync mid-ISSUE with cmd_ready low
    start(1, 1, 4000, 32'h2_0000, 0);
    chk("rs_drop1", cmd_valid, 0);
    tick();
    chk("rs_drop2", cmd_valid, 0);
    tick();
    chk("rs_t3", cmd_valid, 1);
    chk("rs_a0", cmd_addr, 32'h2_0000);
    chk("rs_l0", cmd_len, R_LEN0);
    clear();
    cmd_ready = 1;
    run(100, 1);
    chk("rs_n", q_len.size(), R_N);
    chk("rs_fd", n_fd, 1);
    tick();

    // hactive 0: no commands, frame_done at T+3
    clear();
    start(0, 720, 0, 0, 0);
    chk("h0_t1", frame_done, 0);
    tick();
    chk("h0_t2", frame_done, 0);
    tick();
    chk("h0_t3", frame_done, 1);
    chk("h0_valid", cmd_valid, 0);
    tick();
    chk("h0_pulse", frame_done, 0);
    chk("h0_idle", busy, 0);
    chk("h0_n", q_len.size(), 0);

    // 4 KB boundary case
    clear();
    start(1, 1, 1920, 32'hF00, 0);
    run(100, 1);
    chk("k4_n", q_len.size(), K_N);
    for (int i = 0; i < K_N; i++) begin
      chk($sformatf("k4_a%0d", i), q_addr[i], 32'(k_addr[i]));
      chk($sformatf("k4_l%0d", i), q_len[i], k_len[i]);
      chk($sformatf("k4_t%0d", i), q_tail[i], 1);
    end
    chk("k4_last", q_last[K_N-1], 1);
    chk("k4_fd", n_fd, 1);
    tick();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/read_burst_planner.md
# read_burst_planner

Frame/line read-burst planner for the VDMA read path. On each `fsync` it computes the total AXI beats for the frame (ONCE mode) or per line (LINE mode), then emits addressed burst commands of at most `MAX_BURST` beats through a valid/ready handshake, with a shortened final (tail) burst. It sits between the timing/sync logic and the AXI read-address channel driver. It also throttles outstanding bursts using completion pulses.

## Interface
Parameters:
- `MAX_BURST`, 200, maximum beats per burst; must be ≥1 and < 2^LSIZE
- `AXI_DSIZE`, 256, AXI data width in bits; must be a power of two and ≥8
- `DSIZE`, 24, pixel width in bits
- `LSIZE`, 9, width of `cmd_len`
- `ASIZE`, 32, address width
- `MAX_OUTSTANDING`, 4, maximum number of accepted bursts not yet completed; ≥1

Ports:
- `clock` in 1, single clock
- `rst_n` in 1, asynchronous active-low reset
- `fsync` in 1, one-cycle frame start pulse
- `mode_line` in 1, 0 = ONCE (whole frame contiguous), 1 = LINE (per-line, strided); sampled at `fsync`
- `vactive` in 16, lines per frame; sampled at `fsync`
- `hactive` in 16, pixels per line; sampled at `fsync`
- `base_addr` in ASIZE, frame byte address; sampled at `fsync`
- `line_stride` in ASIZE, byte distance between line starts (LINE mode); sampled at `fsync`
- `cmd_valid` out 1, command present
- `cmd_ready` in 1, command accepted when both are high
- `cmd_addr` out ASIZE, burst byte address
- `cmd_len` out LSIZE, burst length in beats (actual count, not minus one)
- `cmd_tail` out 1, `cmd_len` < `MAX_BURST`
- `cmd_last` out 1, final burst of the frame
- `burst_done` in 1, one-cycle pulse per completed burst
- `busy` out 1, FSM not IDLE
- `frame_done` out 1, one-cycle pulse when all bursts are issued and completed

## Operation
- Unit beats: `BEATS = ceil(PIX*DSIZE / AXI_DSIZE)`.
  - PIX = `hactive` in LINE mode; PIX = `vactive*hactive` in ONCE mode.
  - Computed with a 32-bit product, a shift by log2(AXI_DSIZE), and +1 if any remainder bits are set.
- Byte advance per burst: `cmd_len * AXI_DSIZE/8`.
- States:
  - IDLE: on `fsync`, latch inputs and go to CALC0.
  - CALC0: register the product, then go to CALC1.
  - CALC1: register BEATS, set remaining = BEATS, set lines_left = (LINE ? `vactive` : 1), set line_addr = `base_addr`.
    - If BEATS==0 or lines_left==0, go to DONE.
    - Otherwise go to ISSUE.
  - ISSUE: present `cmd_len` = min(remaining, MAX_BURST) and `cmd_addr` = the current address. Hold the command until handshake.
    - On handshake: remaining -= len, addr += bytes.
    - If remaining hits 0 and lines_left>1: go to NEXT.
    - If remaining hits 0 and this was the last line: go to DRAIN.
  - NEXT: line_addr += `line_stride`, addr = line_addr, remaining = BEATS, lines_left -= 1, then go to ISSUE.
  - DRAIN: wait for outstanding==0, then go to DONE.
  - DONE: pulse `frame_done` for one cycle, then go to IDLE.
- Outstanding counter, width clog2(MAX_OUTSTANDING+1):
  - +1 on handshake, −1 on `burst_done`; both in the same cycle leaves it unchanged.
  - `burst_done` at 0 is ignored (saturates).
  - `cmd_valid` is held low while outstanding==MAX_OUTSTANDING.
- `fsync` outside IDLE restarts the frame: go to CALC0 and drop any pending unaccepted command. The outstanding counter is not cleared; it keeps tracking `burst_done`.
- `cmd_last` = last line and len==remaining.

## Timing
- Reset values: `cmd_valid`=0, `cmd_addr`=0, `cmd_len`=0, `cmd_tail`=0, `cmd_last`=0, `busy`=0, `frame_done`=0; FSM in IDLE, counters cleared.
- All outputs are registered.
- `fsync` at cycle T gives `cmd_valid` high at T+3 at the earliest (CALC0 at T+1, CALC1 at T+2).
- Back-to-back: after a handshake in cycle N, the next command is valid in N+1 when budget allows.
- A line change costs one bubble cycle (NEXT).
- `frame_done` asserts the cycle after DRAIN sees outstanding==0.

## Configuration
- `RD_BURST_4K_SPLIT_EN` defined: burst length = min(remaining, MAX_BURST, (4096 − addr[11:0]) / (AXI_DSIZE/8)). No burst crosses a 4 KB boundary, and `cmd_tail` is still len<MAX_BURST.
- `RD_BURST_4K_SPLIT_EN` undefined: length = min(remaining, MAX_BURST). No boundary logic is built.

## Structure
- Package `read_burst_pkg`:
  - FSM state enum
  - `BYTES_PER_BEAT` and `BEAT_SHIFT` derivation functions
  - `clog2` function
- Sub-module `burst_len_clip`: combinational min of remaining, MAX_BURST, and the optional 4K limit. It outputs len and tail.

## Test plan
- ONCE, 1280x720, DSIZE 24, AXI 256, MAX_BURST 200, `cmd_ready`=1, `burst_done` returned promptly → 432 bursts of 200, no `cmd_tail`, `cmd_last` on the 432nd, `frame_done` once.
- LINE, `vactive` 3, `hactive` 4000, stride 0x4000, base 0 → per line 200@+0 then 175 (tail)@+6400; line starts 0, 0x4000, 0x8000; 6 commands.
- LINE, `hactive` 1366 → BEATS 129 (rounded up), single tail burst per line.
- MAX_OUTSTANDING 4, `burst_done` withheld → exactly 4 handshakes, then `cmd_valid` low. Handshake and `burst_done` in the same cycle → counter unchanged.
- `fsync` mid-ISSUE with `cmd_ready`=0 → command withdrawn, new frame's first command at T+3; `hactive`=0 → no commands, `frame_done` at T+3.
- With `RD_BURST_4K_SPLIT_EN`, LINE `hactive` 1920, base 0xF00 → bursts 8@0xF00, 128@0x1000, 44@0x2000. Without the macro → single 180@0xF00.
